// File: rtl/montre_nios2_qsys_0_oci_dct_packer.sv
// OCI DCT packer: shifts 2-bit trace atoms into a 15-entry accumulator and hands closed frames downstream.
// Optional idle-timeout close is enabled by defining MONTRE_OCI_DCT_TIMEOUT_EN.
//
// state | meaning
// ACCUM | accumulator holds 0..14 atoms, input accepted
// FULL  | accumulator holds 15 atoms, input blocked until the frame transfers
module montre_nios2_qsys_0_oci_dct_packer #(
    parameter int unsigned FLUSH_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        atm_valid,
    input  logic [1:0]  atm_code,
    output logic        atm_ready,
    input  logic        flush,
    output logic        frm_valid,
    input  logic        frm_ready,
    output logic [29:0] frm_data,
    output logic [3:0]  frm_count,
    output logic [29:0] dct_buffer,
    output logic [3:0]  dct_count
);

    typedef enum logic {
        ACCUM = 1'b0,
        FULL  = 1'b1
    } state_t;

    // Clamp keeps an out-of-range zero from making the timeout fire immediately.
    localparam logic [7:0] TIMEOUT_TC = (FLUSH_TIMEOUT == 0) ? 8'd1 : 8'(FLUSH_TIMEOUT);

    state_t      state_q;
    state_t      state_d;
    logic        flush_pend;
    logic        flush_pend_d;
    logic        timeout_hit;
    logic        accept;
    logic        out_free;
    logic        close;
    logic        xfer;
    logic [29:0] buf_d;
    logic [3:0]  cnt_d;

    assign atm_ready = (dct_count != 4'd15);

    always_comb begin
        accept       = atm_valid & atm_ready;
        out_free     = !frm_valid | frm_ready;
        close        = (state_q == FULL)
                     | ((flush_pend | flush | timeout_hit) & (dct_count != 4'd0));
        xfer         = close & out_free;
        buf_d        = dct_buffer;
        cnt_d        = dct_count;
        flush_pend_d = flush_pend;

        // An atom accepted on a transfer edge starts the next frame.
        if (xfer) begin
            buf_d = accept ? {28'b0, atm_code} : 30'b0;
            cnt_d = accept ? 4'd1 : 4'd0;
        end else if (accept) begin
            buf_d = {dct_buffer[27:0], atm_code};
            cnt_d = dct_count + 4'd1;
        end

        if (xfer || dct_count == 4'd0)
            flush_pend_d = 1'b0;
        else if (flush)
            flush_pend_d = 1'b1;

        state_d = (cnt_d == 4'd15) ? FULL : ACCUM;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ACCUM;
            dct_buffer <= 30'b0;
            dct_count  <= 4'd0;
            flush_pend <= 1'b0;
            frm_valid  <= 1'b0;
            frm_data   <= 30'b0;
            frm_count  <= 4'd0;
        end else begin
            state_q    <= state_d;
            dct_buffer <= buf_d;
            dct_count  <= cnt_d;
            flush_pend <= flush_pend_d;
            if (xfer) begin
                frm_valid <= 1'b1;
                frm_data  <= dct_buffer;
                frm_count <= dct_count;
            end else if (frm_valid && frm_ready) begin
                frm_valid <= 1'b0;
            end
        end
    end

`ifdef MONTRE_OCI_DCT_TIMEOUT_EN
    logic [7:0] idle_cnt;

    always_ff @(posedge clk) begin
        if (reset)
            idle_cnt <= 8'd0;
        else if (accept || xfer || dct_count == 4'd0)
            idle_cnt <= 8'd0;
        else if (idle_cnt != TIMEOUT_TC)
            idle_cnt <= idle_cnt + 8'd1;
    end

    assign timeout_hit = (idle_cnt == TIMEOUT_TC);
`else
    // Always false: TIMEOUT_TC is never zero.
    assign timeout_hit = (TIMEOUT_TC == 8'd0);
`endif

endmodule

// File: tb/tb_montre_nios2_qsys_0_oci_dct_packer.sv
// Directed bench for the OCI DCT packer: reset, full/flush/busy/backpressure frames, idle timeout.
// Timeout expectations follow MONTRE_OCI_DCT_TIMEOUT_EN as seen by this compile.
module tb_montre_nios2_qsys_0_oci_dct_packer;

    logic        clk;
    logic        reset;
    logic        atm_valid;
    logic [1:0]  atm_code;
    logic        atm_ready;
    logic        flush;
    logic        frm_valid;
    logic        frm_ready;
    logic [29:0] frm_data;
    logic [3:0]  frm_count;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;

    int n_vec = 0;
    int n_err = 0;

    montre_nios2_qsys_0_oci_dct_packer #(.FLUSH_TIMEOUT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .atm_valid  (atm_valid),
        .atm_code   (atm_code),
        .atm_ready  (atm_ready),
        .flush      (flush),
        .frm_valid  (frm_valid),
        .frm_ready  (frm_ready),
        .frm_data   (frm_data),
        .frm_count  (frm_count),
        .dct_buffer (dct_buffer),
        .dct_count  (dct_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_atom(input logic [1:0] code);
        atm_valid = 1'b1;
        atm_code  = code;
        tick();
        atm_valid = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    initial begin
        int accepts;
        int cyc;

        reset     = 1'b1;
        atm_valid = 1'b1;
        atm_code  = 2'd1;
        flush     = 1'b0;
        frm_ready = 1'b0;
        tick();
        tick();
        chk("rst_frm_valid",  32'(frm_valid),  32'd0);
        chk("rst_frm_data",   32'(frm_data),   32'd0);
        chk("rst_frm_count",  32'(frm_count),  32'd0);
        chk("rst_dct_buffer", 32'(dct_buffer), 32'd0);
        chk("rst_dct_count",  32'(dct_count),  32'd0);
        chk("rst_atm_ready",  32'(atm_ready),  32'd1);
        reset     = 1'b0;
        atm_valid = 1'b0;
        tick();
        chk("post_rst_frm_valid", 32'(frm_valid), 32'd0);

        // Full frame: 15 atoms 0,1,2,3,... then a 16th held during the FULL cycle
        frm_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            atm_valid = 1'b1;
            atm_code  = 2'(i % 4);
            tick();
        end
        chk("full_count15",    32'(dct_count), 32'd15);
        chk("full_ready_low",  32'(atm_ready), 32'd0);
        chk("full_no_frm_yet", 32'(frm_valid), 32'd0);
        atm_code = 2'd3;
        tick();
        chk("full_frm_valid", 32'(frm_valid), 32'd1);
        chk("full_frm_data",  32'(frm_data),  32'h06C6C6C6);
        chk("full_frm_count", 32'(frm_count), 32'd15);
        chk("full_cleared",   32'(dct_count), 32'd0);
        chk("full_ready_ret", 32'(atm_ready), 32'd1);
        tick();
        atm_valid = 1'b0;
        chk("atom16_count",  32'(dct_count),  32'd1);
        chk("atom16_buffer", 32'(dct_buffer), 32'd3);
        chk("full_drained",  32'(frm_valid),  32'd0);
        pulse_flush();
        chk("single_frm_count", 32'(frm_count), 32'd1);
        chk("single_frm_data",  32'(frm_data),  32'd3);
        tick();

        // Flush: 5 atoms of code 3
        for (int i = 0; i < 5; i++) put_atom(2'd3);
        pulse_flush();
        chk("flush_frm_valid", 32'(frm_valid), 32'd1);
        chk("flush_frm_data",  32'(frm_data),  32'h3FF);
        chk("flush_frm_count", 32'(frm_count), 32'd5);
        chk("flush_dct_count", 32'(dct_count), 32'd0);
        tick();
        chk("flush_drained", 32'(frm_valid), 32'd0);

        // Flush while the frame register is busy
        frm_ready = 1'b0;
        put_atom(2'd1);
        put_atom(2'd1);
        pulse_flush();
        chk("busy_first_frm", 32'(frm_data), 32'h5);
        for (int i = 0; i < 3; i++) put_atom(2'd2);
        pulse_flush();
        tick();
        tick();
        tick();
        chk("busy_hold_valid", 32'(frm_valid), 32'd1);
        chk("busy_hold_data",  32'(frm_data),  32'h5);
        chk("busy_hold_count", 32'(frm_count), 32'd2);
        chk("busy_hold_dct",   32'(dct_count), 32'd3);
        frm_ready = 1'b1;
        tick();
        chk("busy_xfer_valid", 32'(frm_valid), 32'd1);
        chk("busy_xfer_data",  32'(frm_data),  32'h2A);
        chk("busy_xfer_count", 32'(frm_count), 32'd3);
        chk("busy_xfer_dct",   32'(dct_count), 32'd0);
        tick();
        chk("busy_drained", 32'(frm_valid), 32'd0);

        // Backpressure: 30 accepts with frm_ready low
        frm_ready = 1'b0;
        accepts   = 0;
        cyc       = 0;
        while (accepts < 30 && cyc < 100) begin
            atm_valid = 1'b1;
            atm_code  = 2'(accepts % 4);
            if (atm_ready) accepts++;
            tick();
            cyc++;
        end
        atm_valid = 1'b0;
        chk("bp_accepts",    32'(accepts),   32'd30);
        chk("bp_ready_low",  32'(atm_ready), 32'd0);
        chk("bp_dct_count",  32'(dct_count), 32'd15);
        chk("bp_frm1_valid", 32'(frm_valid), 32'd1);
        chk("bp_frm1_data",  32'(frm_data),  32'h06C6C6C6);
        tick();
        tick();
        tick();
        chk("bp_hold_data",  32'(frm_data),  32'h06C6C6C6);
        chk("bp_hold_valid", 32'(frm_valid), 32'd1);
        chk("bp_hold_ready", 32'(atm_ready), 32'd0);
        frm_ready = 1'b1;
        tick();
        chk("bp_frm2_valid", 32'(frm_valid), 32'd1);
        chk("bp_frm2_data",  32'(frm_data),  32'h31B1B1B1);
        chk("bp_frm2_count", 32'(frm_count), 32'd15);
        chk("bp_frm2_ready", 32'(atm_ready), 32'd1);
        tick();
        chk("bp_drained", 32'(frm_valid), 32'd0);

        // Idle timeout with FLUSH_TIMEOUT = 4
        put_atom(2'd2);
        put_atom(2'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("to_early", 32'(frm_valid), 32'd0);
        end
        tick();
`ifdef MONTRE_OCI_DCT_TIMEOUT_EN
        chk("to_frm_valid", 32'(frm_valid), 32'd1);
        chk("to_frm_count", 32'(frm_count), 32'd2);
        chk("to_frm_data",  32'(frm_data),  32'h9);
        tick();
`else
        chk("to_no_frame", 32'(frm_valid), 32'd0);
        for (int i = 0; i < 10; i++) tick();
        chk("to_still_none", 32'(frm_valid), 32'd0);
        chk("to_dct_kept",   32'(dct_count), 32'd2);
        pulse_flush();
        chk("to_flush_count", 32'(frm_count), 32'd2);
        tick();
`endif
        chk("to_drained", 32'(frm_valid), 32'd0);

        // Reset mid-frame discards held frame and partial accumulator
        frm_ready = 1'b0;
        for (int i = 0; i < 3; i++) put_atom(2'd1);
        pulse_flush();
        put_atom(2'd3);
        put_atom(2'd3);
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        frm_ready = 1'b1;
        chk("mid_rst_valid",  32'(frm_valid),  32'd0);
        chk("mid_rst_dct",    32'(dct_count),  32'd0);
        chk("mid_rst_buffer", 32'(dct_buffer), 32'd0);
        chk("mid_rst_data",   32'(frm_data),   32'd0);
        for (int i = 0; i < 8; i++) tick();
        chk("mid_rst_no_frame", 32'(frm_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
